// File: rtl/spart_rx.sv
// -----------------------------------------------------------------------------
// spart_rx -- SPART serial receive stage.
//
// Synchronises the raw rxd line, oversamples it at 16 ticks per bit using a
// programmable clock divisor, deframes 8N1 characters (LSB first) and holds the
// last byte together with a data-available flag and sticky error flags until
// the bus interface acknowledges it with a single-cycle rd pulse.
//
// Ports
//   clk_i          system clock (only clock)
//   rst_i          asynchronous, active-high reset
//   rxd_i          serial input, idle high, asynchronous to clk_i
//   divisor_i      clk_i cycles per oversample tick (0 behaves as 1)
//   rd_i           single-cycle acknowledge; consumes the byte, clears flags
//   rx_data_o      last received byte
//   rda_o          byte available, sticky until rd_i
//   framing_err_o  stop bit of the last byte sampled low, sticky until rd_i
//   overrun_o      a byte completed while rda_o was already set
//   busy_o         receiver is inside a frame (state is not IDLE)
// -----------------------------------------------------------------------------
module spart_rx (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rxd_i,
  input  logic [15:0] divisor_i,
  input  logic        rd_i,
  output logic [7:0]  rx_data_o,
  output logic        rda_o,
  output logic        framing_err_o,
  output logic        overrun_o,
  output logic        busy_o
);

  // Ticks per bit period; the tick counter below is sized for exactly this.
  localparam int unsigned OVERSAMPLE = 16;
  localparam logic [3:0]  TICK_MID   = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]  TICK_LAST  = 4'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Synchroniser and edge-detect history
  logic        sync1_q;
  logic        sync2_q;
  logic        rxs_prev_q;
  logic        rxs_s;
  logic        start_edge_s;

  // Tick generator
  logic [15:0] div_eff_s;
  logic [15:0] div_cnt_q;
  logic [15:0] div_cnt_d;
  logic        tick_s;
  logic        reload_s;

  // Deframing state
  state_t      state_q;
  logic [3:0]  os_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        done_q;
  logic        stop_bit_q;
  logic        busy_q;

  // Output registers
  logic [7:0]  rx_data_q;
  logic        rda_q;
  logic        framing_err_q;
  logic        overrun_q;

  assign rxs_s        = sync2_q;
  assign start_edge_s = rxs_prev_q & ~rxs_s;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  // All flops reset to the idle-high line level so reset never looks like a
  // start edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rxd_i;
      sync2_q    <= sync1_q;
      rxs_prev_q <= rxs_s;
    end
  end

  assign div_eff_s = (divisor_i == 16'd0) ? 16'd1 : divisor_i;
  assign tick_s    = (div_cnt_q == 16'd0);
  // A start edge restarts the divisor so every sample point is phase-aligned
  // to the detected edge rather than to a free-running tick.
  assign reload_s  = (state_q == ST_IDLE) && start_edge_s;

  // Tick generator next-count: reload on terminal count or forced reload.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (reload_s || tick_s) begin
      div_cnt_d = div_eff_s - 16'd1;
    end else begin
      div_cnt_d = div_cnt_q - 16'd1;
    end
  end

  // Tick generator count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt_q <= 16'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // Deframing state machine: start validation, data shifting, stop sampling.
  // busy_q tracks every state transition so it is registered alongside state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      os_cnt_q   <= 4'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      done_q     <= 1'b0;
      stop_bit_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_edge_s) begin
            state_q  <= ST_START;
            os_cnt_q <= 4'd0;
            busy_q   <= 1'b1;
          end
        end
        ST_START: begin
          if (tick_s) begin
            if (os_cnt_q == TICK_MID) begin
              if (rxs_s) begin
                // Line is high again at mid start bit: a glitch, not a frame.
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q   <= ST_DATA;
                os_cnt_q  <= 4'd0;
                bit_cnt_q <= 3'd0;
              end
            end else begin
              os_cnt_q <= os_cnt_q + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick_s) begin
            // Counter wraps 15 -> 0, so each bit starts a fresh 16-tick window.
            os_cnt_q <= os_cnt_q + 4'd1;
            if (os_cnt_q == TICK_LAST) begin
              shift_q   <= {rxs_s, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_q <= ST_STOP;
              end
            end
          end
        end
        ST_STOP: begin
          if (tick_s) begin
            os_cnt_q <= os_cnt_q + 4'd1;
            if (os_cnt_q == TICK_LAST) begin
              stop_bit_q <= rxs_s;
              done_q     <= 1'b1;
              state_q    <= ST_IDLE;
              busy_q     <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Output flags and data. A completing byte takes priority over rd_i: the
  // new byte stays available, and a concurrent read suppresses overrun
  // because the old byte was consumed in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_data_q     <= 8'h00;
      rda_q         <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else if (done_q) begin
      rx_data_q     <= shift_q;
      rda_q         <= 1'b1;
      framing_err_q <= ~stop_bit_q;
      overrun_q     <= rd_i ? 1'b0 : (overrun_q | rda_q);
    end else if (rd_i && rda_q) begin
      rda_q         <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      rx_data_q     <= rx_data_q;
      rda_q         <= rda_q;
      framing_err_q <= framing_err_q;
      overrun_q     <= overrun_q;
    end
  end

  assign rx_data_o     = rx_data_q;
  assign rda_o         = rda_q;
  assign framing_err_o = framing_err_q;
  assign overrun_o     = overrun_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_spart_rx.sv
module tb_spart_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic        rd  = 1'b0;
  logic [15:0] divisor = 16'd8;
  logic [7:0]  rx_data;
  logic        rda;
  logic        framing_err;
  logic        overrun;
  logic        busy;

  int   cyc      = 0;
  int   rise_cyc = -1;
  logic rda_prev = 1'b0;
  int   n_pass   = 0;
  int   n_total  = 0;

  // Behavioural reference: what the bus interface should see.
  logic [7:0] m_data;
  bit         m_rda;
  bit         m_fe;
  bit         m_ov;

  typedef struct {
    logic [7:0]  data;
    bit          stop;
    logic [15:0] div;
    int          gap;
    bit          do_rd;
    bit          chk_lat;
    logic [7:0]  e_data;
    bit          e_fe;
    bit          e_ov;
  } vec_t;

  vec_t tbl[8];

  spart_rx dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rxd_i        (rxd),
    .divisor_i    (divisor),
    .rd_i         (rd),
    .rx_data_o    (rx_data),
    .rda_o        (rda),
    .framing_err_o(framing_err),
    .overrun_o    (overrun),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle at which rda was first seen high.
  always @(negedge clk) begin
    if (rda && !rda_prev) rise_cyc = cyc;
    rda_prev = rda;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input logic [7:0] b, input bit stop, input int de);
    logic [7:0] bb;
    bb  = b;
    rxd = 1'b0;
    wait_cyc(16 * de);
    for (int i = 0; i < 8; i++) begin
      rxd = bb[i];
      wait_cyc(16 * de);
    end
    rxd = stop;
    wait_cyc(16 * de);
    rxd = 1'b1;
  endtask

  task automatic rd_pulse();
    rd = 1'b1;
    wait_cyc(1);
    rd = 1'b0;
  endtask

  // Send one frame and check outputs during its stop bit, optionally reading.
  task automatic run_frame(input string tag, input logic [7:0] b, input bit stop,
                           input logic [15:0] d, input bit do_rd, input bit chk_lat,
                           input logic [7:0] e_data, input bit e_fe, input bit e_ov);
    int de;
    int c0;
    int lat;
    de      = (d == 16'd0) ? 1 : int'(d);
    divisor = d;
    c0      = cyc;
    fork
      drive_frame(b, stop, de);
      begin
        repeat (80 * de) @(posedge clk);
        @(negedge clk);
        chk({tag, ".busy_mid"}, 32'(busy), 32'd1);
      end
      begin
        repeat (156 * de) @(posedge clk);
        @(negedge clk);
        chk({tag, ".rda"},  32'(rda),         32'd1);
        chk({tag, ".data"}, 32'(rx_data),     32'(e_data));
        chk({tag, ".fe"},   32'(framing_err), 32'(e_fe));
        chk({tag, ".ov"},   32'(overrun),     32'(e_ov));
        if (do_rd) begin
          @(posedge clk);
          #1;
          rd_pulse();
          @(negedge clk);
          chk({tag, ".rda_clr"}, 32'(rda),         32'd0);
          chk({tag, ".fe_clr"},  32'(framing_err), 32'd0);
          chk({tag, ".ov_clr"},  32'(overrun),     32'd0);
        end
      end
    join
    if (chk_lat) begin
      lat = rise_cyc - c0;
      n_total++;
      if (rise_cyc > c0 && lat >= 152 * de + 3 && lat <= 152 * de + 5) n_pass++;
      else $display("FAIL %s.latency: got %0d cycles, expected %0d +/-1", tag, lat, 152 * de + 4);
    end
  endtask

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 16'd8, 0,  1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'hE7, 1'b1, 16'd8, 0,  1'b1, 1'b1, 8'hE7, 1'b0, 1'b0};
    tbl[2] = '{8'h24, 1'b1, 16'd8, 20, 1'b1, 1'b1, 8'h24, 1'b0, 1'b0};
    tbl[3] = '{8'h3C, 1'b0, 16'd8, 20, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    tbl[4] = '{8'h11, 1'b1, 16'd8, 0,  1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
    tbl[5] = '{8'h22, 1'b1, 16'd8, 20, 1'b1, 1'b0, 8'h22, 1'b0, 1'b1};
    tbl[6] = '{8'hC3, 1'b1, 16'd0, 10, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};
    tbl[7] = '{8'h96, 1'b1, 16'd1, 10, 1'b1, 1'b1, 8'h96, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset.data", 32'(rx_data), 32'h00);
    chk("reset.rda",  32'(rda),     32'd0);
    rst = 1'b0;
    wait_cyc(5);
    chk("idle.busy", 32'(busy),        32'd0);
    chk("idle.fe",   32'(framing_err), 32'd0);
    chk("idle.ov",   32'(overrun),     32'd0);

    // Directed frame table
    for (int i = 0; i < 8; i++) begin
      run_frame($sformatf("vec%0d", i), tbl[i].data, tbl[i].stop, tbl[i].div,
                tbl[i].do_rd, tbl[i].chk_lat, tbl[i].e_data, tbl[i].e_fe, tbl[i].e_ov);
      wait_cyc(tbl[i].gap);
    end

    // 40-cycle glitch: starts a frame, rejected at mid start bit
    divisor = 16'd8;
    wait_cyc(10);
    rxd = 1'b0;
    wait_cyc(20);
    chk("glitch40.busy_start", 32'(busy), 32'd1);
    wait_cyc(20);
    rxd = 1'b1;
    wait_cyc(100);
    chk("glitch40.busy", 32'(busy), 32'd0);
    chk("glitch40.rda",  32'(rda),  32'd0);

    // 1-cycle glitch: no effect on data or flags
    rxd = 1'b0;
    wait_cyc(1);
    rxd = 1'b1;
    wait_cyc(200);
    chk("glitch1.rda",  32'(rda),         32'd0);
    chk("glitch1.data", 32'(rx_data),     32'h96);
    chk("glitch1.fe",   32'(framing_err), 32'd0);
    chk("glitch1.ov",   32'(overrun),     32'd0);
    chk("glitch1.busy", 32'(busy),        32'd0);

    // Read in the very cycle the second byte completes
    run_frame("sim1", 8'h11, 1'b1, 16'd8, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    fork
      drive_frame(8'h22, 1'b1, 8);
      begin
        repeat (152 * 8 + 3) @(posedge clk);
        #1;
        rd_pulse();
      end
      begin
        repeat (156 * 8) @(posedge clk);
        @(negedge clk);
        chk("sim2.rda",  32'(rda),         32'd1);
        chk("sim2.data", 32'(rx_data),     32'h22);
        chk("sim2.ov",   32'(overrun),     32'd0);
        chk("sim2.fe",   32'(framing_err), 32'd0);
      end
    join
    rd_pulse();
    @(negedge clk);
    chk("sim2.rda_clr", 32'(rda), 32'd0);
    wait_cyc(5);

    // Reset during data bit 4 of 0x5A, with flags left set beforehand
    run_frame("prerst", 8'h7E, 1'b0, 16'd8, 1'b0, 1'b1, 8'h7E, 1'b1, 1'b0);
    wait_cyc(20);
    rxd = 1'b0;
    wait_cyc(16 * 8);
    for (int i = 0; i < 4; i++) begin
      rxd = (i % 2 == 1) ? 1'b1 : 1'b0;
      wait_cyc(16 * 8);
    end
    rxd = 1'b1;
    wait_cyc(8 * 8);
    rst = 1'b1;
    #1;
    chk("midrst.data", 32'(rx_data),     32'h00);
    chk("midrst.rda",  32'(rda),         32'd0);
    chk("midrst.fe",   32'(framing_err), 32'd0);
    chk("midrst.ov",   32'(overrun),     32'd0);
    chk("midrst.busy", 32'(busy),        32'd0);
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(20);
    run_frame("postrst", 8'h81, 1'b1, 16'd8, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0);
    wait_cyc(10);

    // Randomised frames against the reference model
    m_data = 8'h81;
    m_rda  = 1'b0;
    m_fe   = 1'b0;
    m_ov   = 1'b0;
    for (int k = 0; k < 24; k++) begin
      logic [7:0]  b;
      bit          stop;
      bit          do_rd;
      bit          lat_ok;
      logic [15:0] d;
      int          gap;
      b      = 8'($urandom);
      stop   = ($urandom_range(0, 3) != 0);
      do_rd  = ($urandom_range(0, 2) != 0);
      d      = 16'($urandom_range(0, 3));
      gap    = stop ? $urandom_range(0, 6) : $urandom_range(4, 10);
      lat_ok = !m_rda;
      // Model: a completed byte overwrites data, overrun if unread.
      m_ov   = m_ov | m_rda;
      m_rda  = 1'b1;
      m_fe   = !stop;
      m_data = b;
      run_frame($sformatf("rnd%0d", k), b, stop, d, do_rd, lat_ok, m_data, m_fe, m_ov);
      if (do_rd) begin
        m_rda = 1'b0;
        m_fe  = 1'b0;
        m_ov  = 1'b0;
      end
      wait_cyc(gap);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
